// File: rtl/wb_timer_irq_sequencer_if.sv
// Wishbone signals between the interrupt sequencer (master) and the timer bank (slaves).
// CYC and RTY are per-timer; address, strobe and write-enable are shared.
interface wb_timer_irq_sequencer_if #(
  parameter int unsigned N_TIMERS = 4
);
  logic [29:0]         adr;
  logic [N_TIMERS-1:0] cyc;
  logic                stb;
  logic                we;
  logic [N_TIMERS-1:0] rty;

  modport master (
    output adr,
    output cyc,
    output stb,
    output we,
    input  rty
  );

  modport slave (
    input  adr,
    input  cyc,
    input  stb,
    input  we,
    output rty
  );
endinterface

// File: rtl/wb_timer_irq_sequencer.sv
// Round-robin interrupt acknowledge sequencer for a bank of Wishbone timer slaves.
// Grants one pending timer, reads its acknowledge register, and waits for RTY or a timeout.
module wb_timer_irq_sequencer #(
  parameter int unsigned N_TIMERS = 4,
  parameter logic [29:0] ACK_ADR  = 30'h3ffffff9,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        en_i,
  input  logic [N_TIMERS-1:0]         irq_i,
  input  logic [N_TIMERS-1:0]         mask_i,
  wb_timer_irq_sequencer_if.master    bus,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [$clog2(N_TIMERS)-1:0] last_id_o,
  output logic [15:0]                 svc_count_o
);

  localparam int unsigned IdW     = $clog2(N_TIMERS);
  localparam logic [IdW:0] NCnt   = (IdW + 1)'(N_TIMERS);
  localparam logic [7:0]   TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e              state_q, state_d;
  logic [N_TIMERS-1:0] cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [29:0]         adr_q, adr_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [IdW-1:0]      last_id_q, last_id_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [15:0]         svc_count_q, svc_count_d;
  logic [7:0]          tmo_q, tmo_d;

  logic [N_TIMERS-1:0] pend;
  logic                grant_vld;
  logic [IdW-1:0]      grant_id;
  logic [IdW:0]        sum;
  logic [IdW-1:0]      cand;
  logic                rty_g;

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    logic [IdW:0] s;
    s = {1'b0, id} + (IdW + 1)'(1);
    if (s >= NCnt) s = '0;
    return s[IdW-1:0];
  endfunction

  // Circular search: first eligible timer at or after ptr_q.
  always_comb begin
    pend      = irq_i & mask_i;
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_TIMERS); i++) begin
      sum = {1'b0, ptr_q} + (IdW + 1)'(i);
      if (sum >= NCnt) sum = sum - NCnt;
      cand = sum[IdW-1:0];
      if (!grant_vld && pend[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Only the granted timer's retry line matters.
  assign rty_g = bus.rty[last_id_q];

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    last_id_d   = last_id_q;
    ptr_d       = ptr_q;
    svc_count_d = svc_count_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (en_i && grant_vld) begin
          state_d         = StReq;
          cyc_d           = '0;
          cyc_d[grant_id] = 1'b1;
          stb_d           = 1'b1;
          adr_d           = ACK_ADR;
          last_id_d       = grant_id;
          tmo_d           = '0;
        end
      end
      StReq: begin
        // RTY takes priority over the terminal count in the same cycle.
        if (rty_g) begin
          state_d     = StGap;
          cyc_d       = '0;
          stb_d       = 1'b0;
          adr_d       = '0;
          done_d      = 1'b1;
          svc_count_d = svc_count_q + 16'd1;
          ptr_d       = next_id(last_id_q);
        end else if (tmo_q == TmoLast) begin
          state_d   = StGap;
          cyc_d     = '0;
          stb_d     = 1'b0;
          adr_d     = '0;
          timeout_d = 1'b1;
          ptr_d     = next_id(last_id_q);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StGap: begin
        // Lets the acknowledged timer's irq line settle before the next decision.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_id_q   <= '0;
      ptr_q       <= '0;
      svc_count_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      last_id_q   <= last_id_d;
      ptr_q       <= ptr_d;
      svc_count_q <= svc_count_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.adr     = adr_q;
  assign bus.cyc     = cyc_q;
  assign bus.stb     = stb_q;
  assign bus.we      = 1'b0;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign last_id_o   = last_id_q;
  assign svc_count_o = svc_count_q;

endmodule

// File: doc/wb_timer_irq_sequencer.md
# wb_timer_irq_sequencer

Wishbone master-side sequencer that services interrupts from up to `N_TIMERS` timer slaves sharing one address/control bus. It watches the timers' `interrupt_o` lines and picks one pending timer by round-robin. It then runs the acknowledge read cycle (read at `ACK_ADR`) on that timer's dedicated `CYC` line and waits for its `RTY` pulse, with a timeout. It sits between the timer bank and the CPU interrupt input, and reports which timer was serviced.

## Interface
- `N_TIMERS`, 4: number of timer slaves (2..16).
- `ACK_ADR`, 30'h3ffffff9: word address of the timer acknowledge register.
- `TIMEOUT`, 15: max cycles in REQ waiting for `RTY_I` (1..255).
- `CLK_I` input 1: single clock; all logic on rising edge.
- `RST_I` input 1: synchronous, active-high reset.
- `en_i` input 1: 0 = no new grants (an in-flight cycle completes normally).
- `irq_i` input `N_TIMERS`: interrupt lines from timers (timer `interrupt_o`).
- `mask_i` input `N_TIMERS`: 1 = timer eligible for service.
- `RTY_I` input `N_TIMERS`: per-timer `RTY_O` return.
- `ADR_O` output 30: bus address, fixed `ACK_ADR` while `STB_O`=1, else 0.
- `CYC_O` output `N_TIMERS`: one-hot cycle select to granted timer.
- `STB_O` output 1: strobe, shared.
- `WE_O` output 1: always 0 (read only).
- `busy_o` output 1: state != IDLE.
- `done_o` output 1: one-cycle pulse, acknowledge completed.
- `timeout_o` output 1: one-cycle pulse, acknowledge abandoned.
- `last_id_o` output `$clog2(N_TIMERS)`: index of last granted timer.
- `svc_count_o` output 16: successful acknowledges, wraps 16'hffff -> 0.

## Operation
- FSM states: IDLE, REQ, GAP.
- IDLE: `pend = irq_i & mask_i`. If `en_i` and `pend != 0`, grant first set bit at or after `ptr` (circular search). Register `CYC_O` one-hot, `STB_O`=1, `ADR_O`=`ACK_ADR`, `last_id_o`=grant, tmo counter=0, and go to REQ.
- REQ: bus signals held stable. `RTY_I[g]`=1 means: drop `CYC_O`/`STB_O`/`ADR_O` to 0, pulse `done_o`, `svc_count_o`+1, `ptr`=g+1 mod `N_TIMERS`, go to GAP. Otherwise tmo+1. If tmo reaches `TIMEOUT`-1 without RTY: drop bus, pulse `timeout_o`, `ptr`=g+1, go to GAP.
- `RTY_I` bits other than the granted one are ignored in all states.
- GAP: one idle cycle so the cleared timer `irq_i` is sampled fresh; then IDLE.
- `WE_O` constantly 0; `ADR_O` 0 whenever `STB_O`=0.
- `en_i` deasserted in REQ does not abort the cycle.
- Mask changes apply only at the grant decision in IDLE.

## Timing
- Reset (`RST_I`=1 at an edge): next cycle all outputs 0, `svc_count_o`=0, `last_id_o`=0, `ptr`=0, state IDLE. Reset mid-REQ drops `CYC_O`/`STB_O` immediately, with no `done_o`/`timeout_o`.
- Grant latency: `irq_i` pending in cycle t gives `CYC_O`/`STB_O` high in t+1.
- Timer returns `RTY_I` in t+2 (registered slave). Bus drops and `done_o` pulses in t+3, GAP in t+3, IDLE in t+4. Earliest next grant: bus high in t+5.
- Timeout: bus held exactly `TIMEOUT` cycles, `timeout_o` in the following cycle.
- Same-cycle RTY and timeout terminal count: RTY wins (`done_o`, not `timeout_o`).
- Round-robin: with all timers pending continuously, grants rotate 0,1,2,3,0…; no timer waits more than `N_TIMERS` grants.
- `done_o` and `timeout_o` never both high in the same cycle; each is high at most 1 cycle per grant.

## Test plan
- Reset: hold `RST_I` 2 cycles mid-REQ -> all outputs 0 next cycle; `svc_count_o`=0; no pulses.
- Single timer: `irq_i`=4'b0100, slave model returns `RTY_I[2]` one cycle after `STB_O` -> `CYC_O`=4'b0100 for 2 cycles, `ADR_O`=30'h3ffffff9, `WE_O`=0, `done_o` once, `last_id_o`=2, `svc_count_o`=1.
- Fairness: `irq_i`=4'b1111, each re-raised after ack -> grant order 0,1,2,3,0; each ack cycle 4 cycles apart.
- Timeout: `irq_i`=4'b0001, `RTY_I` never asserted, `TIMEOUT`=15 -> `STB_O` high exactly 15 cycles, `timeout_o` pulse, `svc_count_o` unchanged, next grant proceeds from timer 1.
- Mask/enable: `mask_i`=4'b1110 with `irq_i`=4'b0001 -> no bus activity. `en_i`=0 with pending 4'b0010 -> idle; raise `en_i` -> grant timer 1 the next cycle.
- Wrap: preload by 65535 acks (or force) -> next ack makes `svc_count_o` 0.
